// File: rtl/load_mem_unit_pkg.sv
`default_nettype none
// ============================================================================
// load_mem_unit_pkg : load-function encodings, result/metadata types, helpers
// Revision 1.0
// ============================================================================
package load_mem_unit_pkg;

  localparam int ROB_IX_W = 3;

  // RISC-V funct3 encodings of the supported loads
  typedef enum logic [2:0] {
    LF_LB  = 3'b000,
    LF_LH  = 3'b001,
    LF_LW  = 3'b010,
    LF_LBU = 3'b100,
    LF_LHU = 3'b101
  } load_func_e;

  typedef struct packed {
    logic [ROB_IX_W-1:0] rob_ix;
    logic [31:0]         data;
    logic                misalign;
  } load_result_t;

  typedef struct packed {
    logic [ROB_IX_W-1:0] rob_ix;
    load_func_e          func;
    logic [1:0]          off;
    logic                misalign;
  } load_meta_t;

  function automatic logic load_misaligned(input load_func_e func, input logic [1:0] off);
    logic mis;
    case (func)
      LF_LH, LF_LHU: mis = off[0];
      LF_LW:         mis = (off != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_result_fifo.sv
`default_nettype none
// ============================================================================
// load_result_fifo : synchronous result FIFO with flush, head shown when valid
// Revision 1.0
// ============================================================================
module load_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       flush_in,
  input  logic                       push_in,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       pop_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] ptr);
    return (ptr == c_ptr_w'(DEPTH - 1)) ? '0 : ptr + c_ptr_w'(1);
  endfunction

  assign w_pop  = pop_in && (r_count != '0);
  // a full FIFO may still accept when its head leaves in the same cycle
  assign w_push = push_in && ((r_count != c_cnt_w'(DEPTH)) || w_pop);

  always_ff @(posedge clk_in) begin
    if (!rst_in || flush_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push && rst_in && !flush_in) r_mem[r_wr_ptr] <= data_in;
  end

  assign valid_out = (r_count != '0);
  assign data_out  = valid_out ? r_mem[r_rd_ptr] : '0;
  assign count_out = r_count;

endmodule
`default_nettype wire

// File: rtl/load_mem_unit.sv
`default_nettype none
// ============================================================================
// load_mem_unit : BRAM load responder with credit-limited result FIFO
// Revision 1.0
// ============================================================================
module load_mem_unit
  import load_mem_unit_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int OUT_DEPTH   = 4,
  parameter int ADDR_W      = 12
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                valid_in,
  input  logic [31:0]         addr_in,
  input  logic [ROB_IX_W-1:0] rob_ix_in,
  input  logic [2:0]          func_in,
  output logic                ready_out,
  input  logic                flush_in,
  output logic [ADDR_W-1:0]   mem_addr_out,
  input  logic [31:0]         mem_data_in,
  output logic                res_valid_out,
  input  logic                res_ready_in,
  output logic [ROB_IX_W-1:0] res_rob_ix_out,
  output logic [31:0]         res_data_out,
  output logic                res_misalign_out
);

  localparam int c_cnt_w = $clog2(OUT_DEPTH + 1);

  load_meta_t         r_meta [MEM_LATENCY];
  logic [MEM_LATENCY-1:0] r_vld;
  logic [c_cnt_w-1:0] w_fifo_count;
  logic [31:0]        w_used;
  logic               w_fire;
  logic               w_push;
  logic               w_pop;
  logic               w_head_valid;
  load_func_e         w_func;
  load_result_t       w_push_res;
  load_result_t       w_head;
  logic               unused_addr_hi;

  function automatic logic [31:0] extend_load(input load_func_e func, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ext;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (func)
      LF_LB:   ext = {{24{b[7]}}, b};
      LF_LBU:  ext = {24'h0, b};
      LF_LH:   ext = {{16{h[15]}}, h};
      LF_LHU:  ext = {16'h0, h};
      default: ext = word;
    endcase
    return ext;
  endfunction

  // every accepted load holds a credit until its result is popped
  assign w_used       = 32'($countones(r_vld)) + 32'(w_fifo_count);
  assign ready_out    = (w_used < 32'(OUT_DEPTH)) && !flush_in;
  assign w_fire       = valid_in && ready_out;
  assign w_func       = load_func_e'(func_in);
  assign mem_addr_out = addr_in[ADDR_W+1:2];
  assign unused_addr_hi = ^addr_in[31:ADDR_W+2];

  always_ff @(posedge clk_in) begin
    if (!rst_in || flush_in) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_fire;
      for (int i = 1; i < MEM_LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    r_meta[0] <= '{rob_ix:   rob_ix_in,
                   func:     w_func,
                   off:      addr_in[1:0],
                   misalign: load_misaligned(w_func, addr_in[1:0])};
  end

  generate
    for (genvar gi = 1; gi < MEM_LATENCY; gi++) begin : g_meta_stage
      always_ff @(posedge clk_in) r_meta[gi] <= r_meta[gi-1];
    end
  endgenerate

  // the last stage lines up with the BRAM word for that request
  assign w_push     = r_vld[MEM_LATENCY-1];
  assign w_push_res = '{rob_ix:   r_meta[MEM_LATENCY-1].rob_ix,
                        data:     extend_load(r_meta[MEM_LATENCY-1].func,
                                              r_meta[MEM_LATENCY-1].off, mem_data_in),
                        misalign: r_meta[MEM_LATENCY-1].misalign};
  assign w_pop      = w_head_valid && res_ready_in;

  load_result_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH ($bits(load_result_t))
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .flush_in  (flush_in),
    .push_in   (w_push),
    .data_in   (w_push_res),
    .pop_in    (w_pop),
    .data_out  (w_head),
    .valid_out (w_head_valid),
    .count_out (w_fifo_count)
  );

  assign res_valid_out    = w_head_valid;
  assign res_rob_ix_out   = w_head.rob_ix;
  assign res_data_out     = w_head.data;
  assign res_misalign_out = w_head.misalign;

endmodule
`default_nettype wire

// File: tb/tb_load_mem_unit.sv
`default_nettype none
// ============================================================================
// tb_load_mem_unit : vector table, corner sequences and random traffic
// Revision 1.0
// ============================================================================
module tb_load_mem_unit;
  import load_mem_unit_pkg::*;

  localparam int c_lat   = 2;
  localparam int c_depth = 4;

  logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0, res_ready = 1'b0;
  logic [31:0] addr = '0;
  logic [2:0]  rob = '0, func = '0;
  logic        ready, res_valid, res_mis;
  logic [2:0]  res_rob;
  logic [31:0] res_data, mem_data;
  logic [11:0] mem_addr;
  logic [31:0] mem [4096];
  logic [31:0] bram_q1 = '0, bram_q2 = '0;
  int          errors = 0, checks = 0, cyc = 0;

  typedef struct { logic [2:0] rob; logic [31:0] data; logic mis; int cyc; } exp_t;
  exp_t q[$];

  typedef struct { logic [2:0] func; logic [31:0] addr; logic [31:0] word;
                   logic [2:0] rob; logic [31:0] exp_data; logic exp_mis; } vec_t;
  vec_t vecs[15];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bram_q1 <= mem[mem_addr];
    bram_q2 <= bram_q1;
    cyc     <= cyc + 1;
  end
  assign mem_data = bram_q2;

  load_mem_unit #(.MEM_LATENCY(c_lat), .OUT_DEPTH(c_depth), .ADDR_W(12)) dut (
    .clk_in(clk), .rst_in(rst_n), .valid_in(valid), .addr_in(addr), .rob_ix_in(rob),
    .func_in(func), .ready_out(ready), .flush_in(flush), .mem_addr_out(mem_addr),
    .mem_data_in(mem_data), .res_valid_out(res_valid), .res_ready_in(res_ready),
    .res_rob_ix_out(res_rob), .res_data_out(res_data), .res_misalign_out(res_mis)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f)
      LF_LB:   return (b >= 128) ? b - 256 : b;
      LF_LBU:  return b;
      LF_LH:   return (h >= 32768) ? h - 65536 : h;
      LF_LHU:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [2:0] f, input logic [31:0] a);
    if (f == LF_LH || f == LF_LHU) return (a % 2) != 0;
    if (f == LF_LW) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem[(a / 4) % 4096];
  endfunction

  // reference: a queue of outstanding loads in acceptance order
  always @(negedge clk) begin : mon
    logic exp_ready, exp_valid;
    if (!rst_n) begin
      q.delete();
    end else begin
      exp_ready = (q.size() < c_depth) && !flush;
      exp_valid = (q.size() > 0) && (q[0].cyc + c_lat + 1 <= cyc);
      chk("ready_out", 32'(ready), 32'(exp_ready));
      chk("res_valid_out", 32'(res_valid), 32'(exp_valid));
      if (exp_valid && res_valid) begin
        chk("res_rob_ix", 32'(res_rob), 32'(q[0].rob));
        chk("res_data", res_data, q[0].data);
        chk("res_misalign", 32'(res_mis), 32'(q[0].mis));
      end
      if (flush) q.delete();
      else begin
        if (exp_valid && res_ready) void'(q.pop_front());
        if (valid && exp_ready)
          q.push_back('{rob: rob, data: ref_load(func, addr, word_at(addr)),
                        mis: ref_mis(func, addr), cyc: cyc});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input string name, input logic [2:0] f, input logic [31:0] a,
                           input logic [2:0] r, input logic [31:0] exp_d, input logic exp_m);
    int t0;
    bit got;
    step();
    valid = 1'b1; func = f; addr = a; rob = r; res_ready = 1'b1;
    t0 = cyc;
    step();
    valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1'b1;
        chk({name, " latency"}, 32'(cyc - t0), 32'(c_lat + 1));
        chk({name, " rob"}, 32'(res_rob), 32'(r));
        chk({name, " data"}, res_data, exp_d);
        chk({name, " misalign"}, 32'(res_mis), 32'(exp_m));
      end
    end
    chk({name, " timeout"}, 32'(got), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int acc, drops, seen;
    logic [15:0] vpat;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    vecs[0]  = '{LF_LB,  32'h41,   32'h8081_82F3, 3'd5, 32'hFFFF_FF82, 1'b0};
    vecs[1]  = '{LF_LBU, 32'h41,   32'h8081_82F3, 3'd1, 32'h0000_0082, 1'b0};
    vecs[2]  = '{LF_LH,  32'h42,   32'h8081_82F3, 3'd2, 32'hFFFF_8081, 1'b0};
    vecs[3]  = '{LF_LW,  32'h40,   32'h8081_82F3, 3'd3, 32'h8081_82F3, 1'b0};
    vecs[4]  = '{LF_LHU, 32'h42,   32'h8081_82F3, 3'd4, 32'h0000_8081, 1'b0};
    vecs[5]  = '{LF_LB,  32'h40,   32'h8081_82F3, 3'd6, 32'hFFFF_FFF3, 1'b0};
    vecs[6]  = '{LF_LBU, 32'h43,   32'h8081_82F3, 3'd7, 32'h0000_0080, 1'b0};
    vecs[7]  = '{LF_LH,  32'h40,   32'h8081_82F3, 3'd0, 32'hFFFF_82F3, 1'b0};
    vecs[8]  = '{LF_LW,  32'h42,   32'h8081_82F3, 3'd2, 32'h8081_82F3, 1'b1};
    vecs[9]  = '{LF_LH,  32'h43,   32'h8081_82F3, 3'd3, 32'hFFFF_8081, 1'b1};
    vecs[10] = '{LF_LB,  32'h43,   32'h8081_82F3, 3'd4, 32'hFFFF_FF80, 1'b0};
    vecs[11] = '{LF_LHU, 32'h41,   32'h8081_82F3, 3'd5, 32'h0000_82F3, 1'b1};
    vecs[12] = '{LF_LB,  32'h45,   32'h1234_5678, 3'd6, 32'h0000_0056, 1'b0};
    vecs[13] = '{LF_LH,  32'h46,   32'h1234_5678, 3'd7, 32'h0000_1234, 1'b0};
    vecs[14] = '{LF_LW,  32'h4040, 32'h8081_82F3, 3'd1, 32'h8081_82F3, 1'b0};

    // reset held for three edges, then released with no traffic
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset res_valid", 32'(res_valid), 32'(0));
    chk("reset ready", 32'(ready), 32'(1));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle res_valid", 32'(res_valid), 32'(0));
    chk("idle ready", 32'(ready), 32'(1));

    foreach (vecs[i]) begin
      mem[(vecs[i].addr / 4) % 4096] = vecs[i].word;
      issue_one($sformatf("vec%0d", i), vecs[i].func, vecs[i].addr, vecs[i].rob,
                vecs[i].exp_data, vecs[i].exp_mis);
    end

    // backpressure: only OUT_DEPTH loads fit while the CDB stalls
    for (int i = 0; i < 256; i++) mem[64 + i] = $urandom;
    step();
    res_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      valid = 1'b1; func = LF_LW; addr = 32'h100 + 32'(4 * i); rob = 3'(i);
      @(negedge clk);
      if (ready) acc++;
    end
    chk("bp accepted", 32'(acc), 32'(c_depth));
    chk("bp ready low", 32'(ready), 32'(0));
    step();
    valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    chk("bp ready held", 32'(ready), 32'(0));
    seen = int'(res_valid);
    @(negedge clk);
    chk("bp ready back", 32'(ready), 32'(1));
    seen += int'(res_valid);
    repeat (2) begin
      @(negedge clk);
      seen += int'(res_valid);
    end
    chk("bp consecutive", 32'(seen), 32'(4));

    // throughput: eight back-to-back words
    drops = 0;
    vpat = '0;
    for (int t = 0; t < 14; t++) begin
      step();
      valid = (t < 8); func = LF_LW; addr = 32'h200 + 32'(4 * t); rob = 3'(t); res_ready = 1'b1;
      @(negedge clk);
      if (t < 8 && !ready) drops++;
      vpat[t] = res_valid;
    end
    chk("tp drops", 32'(drops), 32'(0));
    chk("tp pattern", 32'(vpat), 32'h0000_07F8);

    // flush with two results buffered and two in flight
    step();
    valid = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      valid = 1'b1; func = LF_LW; addr = 32'h300 + 32'(4 * i); rob = 3'(i + 4);
    end
    step();
    valid = 1'b1; flush = 1'b1; addr = 32'h310; rob = 3'd7;
    @(negedge clk);
    chk("flush blocks accept", 32'(ready), 32'(0));
    step();
    flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("flush res_valid", 32'(res_valid), 32'(0));
    chk("flush ready", 32'(ready), 32'(1));
    step();
    res_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(res_valid);
    end
    chk("flush no stale", 32'(seen), 32'(0));
    issue_one("post-flush LW", LF_LW, 32'h308, 3'd6, word_at(32'h308), 1'b0);

    // random traffic with occasional flush and reset
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int t = 0; t < 600; t++) begin
      step();
      valid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 4))
        0:       func = LF_LB;
        1:       func = LF_LH;
        2:       func = LF_LW;
        3:       func = LF_LBU;
        default: func = LF_LHU;
      endcase
      addr      = 32'($urandom_range(0, 255));
      rob       = 3'($urandom);
      res_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
    end
    step();
    valid = 1'b0; flush = 1'b0; rst_n = 1'b1; res_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("drain", 32'(q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
